// File: rtl/cache_pkg.sv
// Shared defaults, FSM state encoding and statistics helper for the direct-mapped cache controller.
package cache_pkg;

    localparam int CACHE_WORD_SIZE = 32;
    localparam int CACHE_LINES     = 8;
    localparam int CACHE_INDEX_W   = 3;
    localparam int CACHE_ADDR_W    = 5;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        READ_HIT  = 3'd2,
        FILL      = 3'd3,
        WRITE_MEM = 3'd4
    } cache_state_e;

    // Saturating increment for the hit/miss statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == STAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag arrays for the cache: synchronous write, combinational read by index, cleared on reset.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int cache_size = CACHE_LINES,
    parameter int index      = CACHE_INDEX_W,
    parameter int tag_w      = CACHE_ADDR_W - CACHE_INDEX_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [index-1:0] rd_index_i,
    output logic             rd_valid_o,
    output logic [tag_w-1:0] rd_tag_o,
    input  logic             wr_en_i,
    input  logic [index-1:0] wr_index_i,
    input  logic [tag_w-1:0] wr_tag_i
);

    logic [cache_size-1:0] valid_q;
    logic [tag_w-1:0]      tag_q [cache_size];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < cache_size; i++) begin
                tag_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
            tag_q[wr_index_i]   <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through/no-allocate cache controller (one word per line).
// Optional hit/miss statistics outputs are compiled in with the CACHE_STATS_EN macro.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int word_size   = CACHE_WORD_SIZE,
    parameter int cache_size  = CACHE_LINES,
    parameter int index       = CACHE_INDEX_W,
    parameter int memory_bits = CACHE_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [memory_bits-1:0] cpu_addr,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [word_size-1:0]   cpu_wdata,
    output logic [word_size-1:0]   cpu_rdata,
    output logic                   cpu_ready,
    output logic [memory_bits-1:0] mem_addr,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [word_size-1:0]   mem_wdata,
    input  logic [word_size-1:0]   mem_rdata,
    input  logic                   mem_ready,
    output logic [index-1:0]       ram_index,
    output logic [word_size-1:0]   ram_wdata_out,
    output logic                   ram_write_out,
    output logic                   ram_write_mem,
    output logic                   ram_read,
    input  logic [word_size-1:0]   ram_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);

    localparam int TAG_W = memory_bits - index;

    cache_state_e           state_q, state_d;
    logic [memory_bits-1:0] addr_q, addr_d;
    logic [word_size-1:0]   wdata_q, wdata_d;
    logic [word_size-1:0]   rdata_q, rdata_d;
    logic                   is_write_q, is_write_d;
    logic                   ready_q, ready_d;

    logic [index-1:0]       line_idx;
    logic [TAG_W-1:0]       line_tag;
    logic                   tag_valid;
    logic [TAG_W-1:0]       tag_rd;
    logic                   hit;
    logic                   fill_we;

    assign line_idx = addr_q[index-1:0];
    assign line_tag = addr_q[memory_bits-1:index];
    assign hit      = tag_valid && (tag_rd == line_tag);

    cache_tag_store #(
        .cache_size(cache_size),
        .index     (index),
        .tag_w     (TAG_W)
    ) u_tag_store (
        .clk_i     (clk),
        .reset_i   (reset),
        .rd_index_i(line_idx),
        .rd_valid_o(tag_valid),
        .rd_tag_o  (tag_rd),
        .wr_en_i   (fill_we),
        .wr_index_i(line_idx),
        .wr_tag_i  (line_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            ready_q    <= ready_d;
        end
    end

    // Handshake: a request is taken in IDLE and answered by a one-cycle cpu_ready; the
    // request is still up during that cycle, so IDLE refuses it while ready_q is high.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        is_write_d    = is_write_q;
        ready_d       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        ram_write_out = 1'b0;
        ram_write_mem = 1'b0;
        ram_read      = 1'b0;
        fill_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if ((cpu_read || cpu_write) && !ready_q) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    is_write_d = cpu_write;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (is_write_q) begin
                    ram_write_out = hit;
                    state_d       = WRITE_MEM;
                end else if (hit) begin
                    ram_read = 1'b1;
                    state_d  = READ_HIT;
                end else begin
                    state_d = FILL;
                end
            end
            READ_HIT: begin
                rdata_d = ram_rdata;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            FILL: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (mem_ready) begin
                    // A reset landing on the completion edge must not leave a RAM write behind.
                    ram_write_mem = !reset;
                    fill_we       = !reset;
                    rdata_d       = mem_rdata;
                    ready_d       = 1'b1;
                    state_d       = IDLE;
                end
            end
            WRITE_MEM: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_index     = line_idx;
    assign ram_wdata_out = wdata_q;
    assign cpu_rdata     = rdata_q;
    assign cpu_ready     = ready_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP && !is_write_q) begin
            if (hit) begin
                hit_cnt_q <= sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_q <= sat_inc(miss_cnt_q);
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter word_size, default 32, data word width.
REQ-002 Parameter cache_size, default 8, number of direct-mapped lines (one word per line).
REQ-003 Parameter index, default 3, line-index width (log2 cache_size).
REQ-004 Parameter memory_bits, default 5, word-address width; tag width = memory_bits-index.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
REQ-006 The CPU-side ports SHALL be:
- cpu_addr  in  memory_bits  word address.
- cpu_read  in  1  read request.
- cpu_write  in  1  write request.
- cpu_wdata  in  word_size  write data.
- cpu_rdata  out  word_size  read data.
- cpu_ready  out  1  one-cycle completion pulse.
REQ-007 The memory-side ports SHALL be:
- mem_addr  out  memory_bits  memory address.
- mem_read  out  1  memory read strobe, level until mem_ready.
- mem_write  out  1  memory write strobe, level until mem_ready.
- mem_wdata  out  word_size  memory write data.
- mem_rdata  in  word_size  memory read data.
- mem_ready  in  1  memory completion, one cycle.
REQ-008 The data-RAM-side ports SHALL be:
- ram_index  out  index  line address.
- ram_wdata_out  out  word_size  CPU write data to RAM.
- ram_write_out  out  1  RAM write from CPU.
- ram_write_mem  out  1  RAM write from memory fill.
- ram_read  out  1  RAM read; RAM data is valid at the next posedge.
- ram_rdata  in  word_size  RAM read data.

Function
REQ-009 Address split SHALL be: index = cpu_addr[index-1:0]; tag = cpu_addr[memory_bits-1:index].
REQ-010 FSM states SHALL be IDLE, LOOKUP, READ_HIT, FILL, WRITE_MEM.
REQ-011 In IDLE, a request SHALL be accepted and addr/wdata/op registered.
- If cpu_write and cpu_read are both high, the write wins.
- Requests are sampled only in IDLE; the CPU holds its request until cpu_ready.
REQ-012 LOOKUP SHALL compare the stored tag and valid bit for the index.
- Read hit: assert ram_read, go to READ_HIT.
- Read miss: go to FILL.
- Any write: go to WRITE_MEM.
- Write hit: also pulse ram_write_out with ram_wdata_out = registered wdata.
REQ-013 READ_HIT SHALL capture ram_rdata into cpu_rdata, pulse cpu_ready, and return to IDLE.
- Read-hit latency: cpu_ready is high in the 3rd cycle after the accepting edge.
REQ-014 FILL SHALL hold mem_read=1 with mem_addr = the registered address until mem_ready.
- On the mem_ready cycle: pulse ram_write_mem, set valid and tag, load cpu_rdata = mem_rdata, pulse cpu_ready, and go to IDLE.
REQ-015 WRITE_MEM SHALL hold mem_write=1 with mem_addr/mem_wdata registered until mem_ready, then pulse cpu_ready and go to IDLE.
- Policy is write-through, no-allocate: a write miss does not change the tag or valid bit.
REQ-016 ram_write_out and ram_write_mem SHALL never be high in the same cycle; mem_read and mem_write SHALL never be high in the same cycle.
REQ-017 mem_ready arriving outside FILL or WRITE_MEM SHALL be ignored.

Reset
REQ-018 Reset SHALL clear all valid bits and tags, force state to IDLE, and zero every output.
- Outputs zeroed: cpu_rdata, cpu_ready, mem_*, ram_*.
REQ-019 Reset asserted mid-FILL or mid-WRITE_MEM SHALL abort the operation.
- Strobes are low on the cycle after the reset edge.
- No RAM write occurs.
- No cpu_ready is issued.

Configuration
REQ-020 Macro CACHE_STATS_EN compiled in SHALL add outputs hit_count and miss_count, 16 bits each.
- Each increments once per LOOKUP read hit or read miss respectively.
- Both saturate at 16'hFFFF and are cleared by reset.
- Without the macro, the ports and counters SHALL be absent and the rest of the behaviour is identical.

Structure
REQ-021 Package cache_pkg SHALL hold the default parameters and the FSM state enum.
REQ-022 Sub-module cache_tag_store SHALL hold the valid/tag arrays:
- synchronous write;
- combinational read by index;
- clear on reset.

Verification
REQ-023 Cold miss: reset, read 5'b01011, mem_ready with 32'hDEADBEEF.
- Response: mem_read with mem_addr=11; ram_write_mem at index 3; cpu_rdata=32'hDEADBEEF.
REQ-024 Hit after fill: reread 5'b01011 with the RAM returning 32'hDEADBEEF.
- Response: no mem_read; cpu_ready 3 cycles after acceptance; cpu_rdata=32'hDEADBEEF.
REQ-025 Conflict: read 5'b11011 after REQ-023.
- Response: miss, mem_addr=27, tag of index 3 becomes 2'b11.
REQ-026 Write hit: write 32'h12345678 to 5'b01011.
- Response: ram_write_out at index 3 plus mem_write until mem_ready.
- A write to 5'b00100 (miss) produces no ram_write_out.
REQ-027 Reset during FILL before mem_ready.
- Response: strobes drop next cycle; no cpu_ready; a subsequent read of the same address misses.
REQ-028 With CACHE_STATS_EN: the sequence of REQ-023 to REQ-025 yields hit_count=1, miss_count=2.
